ghost_typist: RTL and testbench

GHOST_TYPIST -- requirements
Module: ghost_typist

---
 rtl/ghost_typist.sv | 225 ++++++++++++++++++++++
 tb/tb_ghost_typist.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_typist.sv
`default_nettype none
// ============================================================================
// Module   : ghost_typist
// Purpose  : Scripted keystroke generator. Types one latched word (letters
//            0..n-1 followed by SPACE) onto the game's keyboard-event
//            interface. Each key is PRESS, HOLD, RELEASE (1 tick each),
//            then a GAP of max(interval,1) ticks.
// Ports    : clk_div     - 100 Hz tick clock, rising edge
//            rst         - asynchronous, active-high reset
//            start       - level-sampled request, honoured only in IDLE
//            word        - letter i in bits [5i+4:5i], a=1 .. z=26
//            wordnum     - letter count, clamped to MAX_CHARS
//            interval    - gap ticks between keystrokes (0 acts as 1)
//            typo_pos    - 1-based letter index for an injected typo, 0=none
//            key_down    - one-hot pressed-key map indexed by scan code
//            last_change - scan code of the most recent press or release
//            key_valid   - one-tick strobe on PRESS and RELEASE
//            busy        - high while a word is in progress
//            done        - one-tick pulse after the trailing SPACE
//            char_idx    - index of the letter currently being typed
// Options  : GHOST_TYPO_EN - when defined, letter typo_pos is first typed
//            as the next letter of the alphabet (z wraps to a), then
//            BACKSPACE, then the correct letter.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_typist #(
    parameter int MAX_CHARS = 15
) (
    input  logic                   clk_div,
    input  logic                   rst,
    input  logic                   start,
    input  logic [5*MAX_CHARS-1:0] word,
    input  logic [4:0]             wordnum,
    input  logic [6:0]             interval,
    input  logic [4:0]             typo_pos,
    output logic [127:0]           key_down,
    output logic [8:0]             last_change,
    output logic                   key_valid,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             char_idx
);

    localparam logic [6:0] C_CODE_BACK  = 7'd102;
    localparam logic [6:0] C_CODE_SPACE = 7'd41;
    localparam logic [4:0] C_MAX_N      = 5'(MAX_CHARS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [5*MAX_CHARS-1:0] r_word;
    logic [4:0]             r_n;
    logic [6:0]             r_gap;
    logic [6:0]             r_cnt;
    logic [4:0]             r_idx;
    logic [6:0]             r_last;
    logic [4:0]             w_n;
    logic [4:0]             w_letter;
    logic [6:0]             w_code;
    logic                   w_retype;
    logic                   w_gap_end;

    function automatic logic [6:0] f_scan(input logic [4:0] l);
        case (l)
            5'd1:  f_scan = 7'd28;  5'd2:  f_scan = 7'd50;
            5'd3:  f_scan = 7'd33;  5'd4:  f_scan = 7'd35;
            5'd5:  f_scan = 7'd36;  5'd6:  f_scan = 7'd43;
            5'd7:  f_scan = 7'd52;  5'd8:  f_scan = 7'd51;
            5'd9:  f_scan = 7'd67;  5'd10: f_scan = 7'd59;
            5'd11: f_scan = 7'd66;  5'd12: f_scan = 7'd75;
            5'd13: f_scan = 7'd58;  5'd14: f_scan = 7'd49;
            5'd15: f_scan = 7'd68;  5'd16: f_scan = 7'd77;
            5'd17: f_scan = 7'd21;  5'd18: f_scan = 7'd45;
            5'd19: f_scan = 7'd27;  5'd20: f_scan = 7'd44;
            5'd21: f_scan = 7'd60;  5'd22: f_scan = 7'd42;
            5'd23: f_scan = 7'd29;  5'd24: f_scan = 7'd34;
            5'd25: f_scan = 7'd53;  5'd26: f_scan = 7'd26;
            default: f_scan = 7'd0;
        endcase
    endfunction

    // First letter index >= from holding a real letter; n means "go to SPACE".
    // Invalid codes are skipped here so they cost neither a keystroke nor a tick.
    function automatic logic [4:0] f_next_valid(input logic [5*MAX_CHARS-1:0] w,
                                                input logic [4:0] n,
                                                input logic [4:0] from);
        logic [4:0] res;
        logic [4:0] l;
        res = n;
        for (int j = MAX_CHARS - 1; j >= 0; j--) begin
            l = w[5*j +: 5];
            if (5'(j) >= from && 5'(j) < n && l >= 5'd1 && l <= 5'd26)
                res = 5'(j);
        end
        return res;
    endfunction

    assign w_n       = (wordnum > C_MAX_N) ? C_MAX_N : wordnum;
    assign w_letter  = (r_idx < C_MAX_N) ? r_word[5*r_idx +: 5] : 5'd0;
    assign w_gap_end = (r_state == ST_GAP) && (r_cnt == 7'd0);

`ifdef GHOST_TYPO_EN
    // r_phase walks 0 (wrong letter) -> 1 (BACKSPACE) -> 2 (correct letter)
    // while parked on the typo letter; it is 0 everywhere else.
    logic [4:0] r_typo;
    logic [1:0] r_phase;
    logic       w_typo_here;

    assign w_typo_here = (r_typo != 5'd0) && (r_typo <= r_n) &&
                         (r_idx == r_typo - 5'd1);
    assign w_retype    = w_typo_here && (r_phase != 2'd2);

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_typo  <= 5'd0;
            r_phase <= 2'd0;
        end else if (r_state == ST_IDLE && start) begin
            r_typo  <= typo_pos;
            r_phase <= 2'd0;
        end else if (w_gap_end) begin
            r_phase <= w_retype ? r_phase + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        w_code = f_scan(w_letter);
        if (r_idx >= r_n)
            w_code = C_CODE_SPACE;
        else if (w_typo_here && r_phase == 2'd0)
            w_code = f_scan((w_letter == 5'd26) ? 5'd1 : w_letter + 5'd1);
        else if (w_typo_here && r_phase == 2'd1)
            w_code = C_CODE_BACK;
    end
`else
    logic w_unused_typo;

    assign w_unused_typo = ^typo_pos;
    assign w_retype      = 1'b0;
    assign w_code        = (r_idx >= r_n) ? C_CODE_SPACE : f_scan(w_letter);
`endif

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        key_down    = '0;
        key_valid   = 1'b0;
        busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done        = (r_state == ST_DONE);
        char_idx    = r_idx;
        last_change = {2'b00, r_last};
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_PRESS;
            ST_PRESS: begin
                key_down[w_code] = 1'b1;
                key_valid        = 1'b1;
                last_change      = {2'b00, w_code};
                w_state_nxt      = ST_HOLD;
            end
            ST_HOLD: begin
                key_down[w_code] = 1'b1;
                last_change      = {2'b00, w_code};
                w_state_nxt      = ST_RELEASE;
            end
            ST_RELEASE: begin
                key_valid   = 1'b1;
                last_change = {2'b00, w_code};
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == 7'd0)
                    w_state_nxt = (!w_retype && r_idx >= r_n) ? ST_DONE : ST_PRESS;
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_n    <= 5'd0;
            r_gap  <= 7'd1;
            r_cnt  <= 7'd0;
            r_idx  <= 5'd0;
            r_last <= 7'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word <= word;
                        r_n    <= w_n;
                        r_gap  <= (interval == 7'd0) ? 7'd1 : interval;
                        r_idx  <= f_next_valid(word, w_n, 5'd0);
                    end
                end
                ST_RELEASE: begin
                    r_cnt  <= r_gap - 7'd1;
                    r_last <= w_code;
                end
                ST_GAP: begin
                    if (r_cnt != 7'd0)
                        r_cnt <= r_cnt - 7'd1;
                    else if (!w_retype && r_idx < r_n)
                        r_idx <= f_next_valid(r_word, r_n, r_idx + 5'd1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ghost_typist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_typist
// Purpose  : Self-checking bench for ghost_typist. A table of words with
//            their hand-computed scan-code sequences and char_idx values is
//            replayed; every tick is checked against a PRESS/HOLD/RELEASE/
//            GAP timing model. Hand-written sequences cover reset mid-key
//            and start re-pulsed while busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_typist;

    logic         clk_div = 1'b0;
    logic         rst;
    logic         start;
    logic [74:0]  word;
    logic [4:0]   wordnum;
    logic [6:0]   interval;
    logic [4:0]   typo_pos;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic [4:0]   char_idx;

    int checks = 0;
    int errors = 0;
    int cur_vec = -1;
    int cur_t   = 0;

    typedef struct {
        logic [74:0]  word;
        logic [4:0]   wn;
        logic [6:0]   itv;
        logic [4:0]   typo;
        int           nkeys;
        logic [111:0] codes;
        logic [79:0]  idxs;
    } vec_t;

    vec_t vecs[8];

    ghost_typist #(.MAX_CHARS(15)) dut (
        .clk_div     (clk_div),
        .rst         (rst),
        .start       (start),
        .word        (word),
        .wordnum     (wordnum),
        .interval    (interval),
        .typo_pos    (typo_pos),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .busy        (busy),
        .done        (done),
        .char_idx    (char_idx)
    );

    always #5 clk_div = ~clk_div;

    function automatic logic [74:0] mk_word(input string s);
        logic [74:0] w;
        w = '0;
        for (int i = 0; i < s.len(); i++)
            w[5*i +: 5] = 5'(s[i] - 8'd96);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d t=%0d got=%h want=%h", nm, cur_vec, cur_t, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [74:0] w, input int wn, input int itv, input int ty);
        vecs[i].word  = w;
        vecs[i].wn    = 5'(wn);
        vecs[i].itv   = 7'(itv);
        vecs[i].typo  = 5'(ty);
        vecs[i].nkeys = 0;
        vecs[i].codes = '0;
        vecs[i].idxs  = '0;
    endtask

    task automatic add_key(input int i, input int code, input int idx);
        vecs[i].codes[7*vecs[i].nkeys +: 7] = 7'(code);
        vecs[i].idxs[5*vecs[i].nkeys +: 5]  = 5'(idx);
        vecs[i].nkeys++;
    endtask

    // Replays one vector and checks every tick from the first PRESS to DONE.
    task automatic run_word(input int vi, input bit repulse);
        int p, total, k, ph;
        logic [6:0]   code;
        logic [127:0] exp_kd;
        bit act;
        cur_vec = vi;
        p     = 3 + ((vecs[vi].itv == 7'd0) ? 1 : int'(vecs[vi].itv));
        total = vecs[vi].nkeys * p;
        @(negedge clk_div);
        word     = vecs[vi].word;
        wordnum  = vecs[vi].wn;
        interval = vecs[vi].itv;
        typo_pos = vecs[vi].typo;
        start    = 1'b1;
        @(negedge clk_div);
        start = 1'b0;
        for (int t = 0; t <= total; t++) begin
            cur_t = t;
            k   = t / p;
            ph  = t % p;
            act = (k < vecs[vi].nkeys);
            code   = act ? vecs[vi].codes[7*k +: 7] : 7'd41;
            exp_kd = '0;
            if (act && ph < 2)
                exp_kd[code] = 1'b1;
            chk("key_down", key_down, exp_kd);
            chk("key_valid", 128'(key_valid), 128'(act && (ph == 0 || ph == 2)));
            chk("last_change", 128'(last_change), 128'(code));
            if (act && ph == 0)
                chk("char_idx", 128'(char_idx), 128'(vecs[vi].idxs[5*k +: 5]));
            chk("busy", 128'(busy), 128'(t < total));
            chk("done", 128'(done), 128'(t == total));
            if (repulse) begin
                start = (t < 12) && (t % 4 == 1);
                word  = mk_word("zz");
            end
            @(negedge clk_div);
        end
        start = 1'b0;
        for (int t = 0; t < (repulse ? 8 : 1); t++) begin
            cur_t = total + 1 + t;
            chk("post_busy", 128'(busy), 128'd0);
            chk("post_done", 128'(done), 128'd0);
            chk("post_valid", 128'(key_valid), 128'd0);
            @(negedge clk_div);
        end
    endtask

    initial begin
        logic [74:0] w;
        rst      = 1'b1;
        start    = 1'b0;
        word     = '0;
        wordnum  = 5'd0;
        interval = 7'd0;
        typo_pos = 5'd0;

        // 0: "cat", interval 2
        set_vec(0, mk_word("cat"), 3, 2, 0);
        add_key(0, 33, 0); add_key(0, 28, 1); add_key(0, 44, 2); add_key(0, 41, 3);
        // 1: empty word -> SPACE only
        set_vec(1, mk_word("cat"), 0, 2, 0);
        add_key(1, 41, 0);
        // 2: interval 0 behaves as 1
        set_vec(2, mk_word("cat"), 3, 0, 0);
        add_key(2, 33, 0); add_key(2, 28, 1); add_key(2, 44, 2); add_key(2, 41, 3);
        // 3: invalid letter codes 0 and 31 are skipped
        w = '0; w[4:0] = 5'd3; w[14:10] = 5'd1; w[19:15] = 5'd31; w[24:20] = 5'd20;
        set_vec(3, w, 5, 1, 0);
        add_key(3, 33, 0); add_key(3, 28, 2); add_key(3, 44, 4); add_key(3, 41, 5);
        // 4: "zq", interval 3
        set_vec(4, mk_word("zq"), 2, 3, 0);
        add_key(4, 26, 0); add_key(4, 21, 1); add_key(4, 41, 2);
        // 5: "cat" with typo on letter 2
        set_vec(5, mk_word("cat"), 3, 1, 2);
`ifdef GHOST_TYPO_EN
        add_key(5, 33, 0); add_key(5, 50, 1); add_key(5, 102, 1); add_key(5, 28, 1);
        add_key(5, 44, 2); add_key(5, 41, 3);
`else
        add_key(5, 33, 0); add_key(5, 28, 1); add_key(5, 44, 2); add_key(5, 41, 3);
`endif
        // 6: wordnum 20 clamps to 15 letters
        set_vec(6, mk_word("eeeeeeeeeeeeeee"), 20, 1, 0);
        for (int i = 0; i < 15; i++) add_key(6, 36, i);
        add_key(6, 41, 15);
        // 7: "z" with typo on letter 1 (wrong letter wraps to a)
        set_vec(7, mk_word("z"), 1, 1, 1);
`ifdef GHOST_TYPO_EN
        add_key(7, 28, 0); add_key(7, 102, 0); add_key(7, 26, 0); add_key(7, 41, 1);
`else
        add_key(7, 26, 0); add_key(7, 41, 1);
`endif

        // Reset state
        #12;
        chk("rst_key_down", key_down, 128'd0);
        chk("rst_last_change", 128'(last_change), 128'd0);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_char_idx", 128'(char_idx), 128'd0);
        @(negedge clk_div);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_word(i, 1'b0);

        // Reset during HOLD of "c", then restart from letter 0
        cur_vec = 100;
        @(negedge clk_div);
        word = mk_word("cat"); wordnum = 5'd3; interval = 7'd2; typo_pos = 5'd0;
        start = 1'b1;
        @(negedge clk_div);
        start = 1'b0;
        cur_t = 0;
        chk("mid_press_valid", 128'(key_valid), 128'd1);
        @(negedge clk_div);
        cur_t = 1;
        chk("mid_hold_key", key_down, 128'd1 << 33);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_key_down", key_down, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_valid", 128'(key_valid), 128'd0);
        chk("mid_rst_char_idx", 128'(char_idx), 128'd0);
        @(negedge clk_div);
        rst = 1'b0;
        repeat (3) @(negedge clk_div);
        chk("idle_after_rst", 128'(busy), 128'd0);
        run_word(0, 1'b0);

        // start re-pulsed while busy must not disturb the sequence
        run_word(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
